// File: rtl/inst_fetch_decode.sv
// Instruction fetch and MIPS-I decode stage.
// Runs a single fetch from instruction memory, captures the returned word and
// presents a one-hot flag vector plus an illegal indication to a downstream
// controller through a valid/ready handshake.
// Optional feature: define ILLEGAL_TRAP_EN to park the block in a TRAP state
// after an illegal word has been handed over; only reset leaves TRAP.
module inst_fetch_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [30:0] inst_flags,
    output logic [31:0] ir,
    output logic        illegal
);

    // Flag bit positions
    localparam int unsigned FlAdd   = 0;
    localparam int unsigned FlAddu  = 1;
    localparam int unsigned FlSub   = 2;
    localparam int unsigned FlSubu  = 3;
    localparam int unsigned FlAnd   = 4;
    localparam int unsigned FlOr    = 5;
    localparam int unsigned FlXor   = 6;
    localparam int unsigned FlNor   = 7;
    localparam int unsigned FlSlt   = 8;
    localparam int unsigned FlSltu  = 9;
    localparam int unsigned FlSll   = 10;
    localparam int unsigned FlSrl   = 11;
    localparam int unsigned FlSra   = 12;
    localparam int unsigned FlSllv  = 13;
    localparam int unsigned FlSrlv  = 14;
    localparam int unsigned FlSrav  = 15;
    localparam int unsigned FlJr    = 16;
    localparam int unsigned FlAddi  = 17;
    localparam int unsigned FlAddiu = 18;
    localparam int unsigned FlAndi  = 19;
    localparam int unsigned FlOri   = 20;
    localparam int unsigned FlXori  = 21;
    localparam int unsigned FlLw    = 22;
    localparam int unsigned FlSw    = 23;
    localparam int unsigned FlBeq   = 24;
    localparam int unsigned FlBne   = 25;
    localparam int unsigned FlSlti  = 26;
    localparam int unsigned FlSltiu = 27;
    localparam int unsigned FlLui   = 28;
    localparam int unsigned FlJ     = 29;
    localparam int unsigned FlJal   = 30;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0A;
    localparam logic [5:0] OpSltiu   = 6'h0B;
    localparam logic [5:0] OpAndi    = 6'h0C;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpXori    = 6'h0E;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpSw      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StValid = 2'd2
`ifdef ILLEGAL_TRAP_EN
        ,
        StTrap  = 2'd3
`endif
    } state_e;

    state_e      state;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [30:0] dec_flags;

    assign op    = imem_rdata[31:26];
    assign funct = imem_rdata[5:0];

    // Combinational decode of the word currently on the memory bus
    always_comb begin
        dec_flags = '0;
        if (op == OpSpecial) begin
            case (funct)
                FnAdd:   dec_flags[FlAdd]  = 1'b1;
                FnAddu:  dec_flags[FlAddu] = 1'b1;
                FnSub:   dec_flags[FlSub]  = 1'b1;
                FnSubu:  dec_flags[FlSubu] = 1'b1;
                FnAnd:   dec_flags[FlAnd]  = 1'b1;
                FnOr:    dec_flags[FlOr]   = 1'b1;
                FnXor:   dec_flags[FlXor]  = 1'b1;
                FnNor:   dec_flags[FlNor]  = 1'b1;
                FnSlt:   dec_flags[FlSlt]  = 1'b1;
                FnSltu:  dec_flags[FlSltu] = 1'b1;
                FnSll:   dec_flags[FlSll]  = 1'b1;
                FnSrl:   dec_flags[FlSrl]  = 1'b1;
                FnSra:   dec_flags[FlSra]  = 1'b1;
                FnSllv:  dec_flags[FlSllv] = 1'b1;
                FnSrlv:  dec_flags[FlSrlv] = 1'b1;
                FnSrav:  dec_flags[FlSrav] = 1'b1;
                FnJr:    dec_flags[FlJr]   = 1'b1;
                default: dec_flags         = '0;
            endcase
        end else begin
            case (op)
                OpAddi:  dec_flags[FlAddi]  = 1'b1;
                OpAddiu: dec_flags[FlAddiu] = 1'b1;
                OpAndi:  dec_flags[FlAndi]  = 1'b1;
                OpOri:   dec_flags[FlOri]   = 1'b1;
                OpXori:  dec_flags[FlXori]  = 1'b1;
                OpLw:    dec_flags[FlLw]    = 1'b1;
                OpSw:    dec_flags[FlSw]    = 1'b1;
                OpBeq:   dec_flags[FlBeq]   = 1'b1;
                OpBne:   dec_flags[FlBne]   = 1'b1;
                OpSlti:  dec_flags[FlSlti]  = 1'b1;
                OpSltiu: dec_flags[FlSltiu] = 1'b1;
                OpLui:   dec_flags[FlLui]   = 1'b1;
                OpJ:     dec_flags[FlJ]     = 1'b1;
                OpJal:   dec_flags[FlJal]   = 1'b1;
                default: dec_flags          = '0;
            endcase
        end
    end

    // Fetch FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            dec_valid  <= 1'b0;
            ir         <= '0;
            inst_flags <= '0;
            illegal    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // imem_ack is deliberately ignored here
                    if (fetch_en) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= StReq;
                    end
                end
                StReq: begin
                    // fetch_en is not looked at: an issued request always completes
                    if (imem_ack) begin
                        ir         <= imem_rdata;
                        inst_flags <= dec_flags;
                        illegal    <= (dec_flags == '0);
                        imem_req   <= 1'b0;
                        dec_valid  <= 1'b1;
                        state      <= StValid;
                    end
                end
                StValid: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
                        if (illegal) begin
                            state <= StTrap;
                        end else
`endif
                        if (fetch_en) begin
                            imem_addr <= pc;
                            imem_req  <= 1'b1;
                            state     <= StReq;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                StTrap: begin
                    // Sticky until reset
                    dec_valid <= 1'b0;
                    imem_req  <= 1'b0;
                    illegal   <= 1'b1;
                end
`endif
                default: begin
                    state     <= StIdle;
                    imem_req  <= 1'b0;
                    dec_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_decode.md
INST_FETCH_DECODE -- requirements
Module: inst_fetch_decode

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 fetch_en  in  1  permit to start a new fetch.
REQ-004 pc  in  32  fetch address, sampled when leaving IDLE or VALID.
REQ-005 imem_req  out  1  instruction-memory request.
REQ-006 imem_addr  out  32  registered copy of sampled pc.
REQ-007 imem_ack  in  1  memory has returned data this cycle.
REQ-008 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-009 dec_valid  out  1  decoded instruction available.
REQ-010 dec_ready  in  1  downstream controller accepts the instruction.
REQ-011 inst_flags  out  31  one-hot instruction flags, bit order: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne, 26 slti, 27 sltiu, 28 lui, 29 j, 30 jal.
REQ-012 ir  out  32  captured instruction word.
REQ-013 illegal  out  1  captured word matches no flag.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 FSM states: IDLE, REQ, VALID, TRAP (TRAP exists only with ILLEGAL_TRAP_EN).
REQ-016 IDLE: fetch_en=1 -> sample pc into imem_addr, go REQ; else stay.
REQ-017 REQ: imem_req=1, imem_addr held stable; imem_ack=1 -> capture imem_rdata into ir, compute inst_flags/illegal, go VALID next edge; unbounded wait states allowed.
REQ-018 Latency: ack at edge N -> dec_valid=1 and flags valid after edge N+1; imem_req=0 from that edge.
REQ-019 VALID: dec_valid=1; ir, inst_flags, illegal held stable until dec_valid&&dec_ready.
REQ-020 Handshake in VALID: fetch_en=1 -> sample pc, go REQ (dec_valid=0 next cycle); fetch_en=0 -> IDLE.
REQ-021 Decoding per MIPS-I: op=0x00 uses funct (add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07, jr 0x08); otherwise op (addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D, xori 0x0E, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, slti 0x0A, sltiu 0x0B, lui 0x0F, j 0x02, jal 0x03).
REQ-022 At most one inst_flags bit SHALL be set; illegal=1 exactly when none set.
REQ-023 Word 0x00000000 SHALL decode as sll (bit 10), not illegal.
REQ-024 imem_ack outside REQ SHALL be ignored.
REQ-025 fetch_en drop during REQ SHALL NOT abort the outstanding request.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, imem_req=0, imem_addr=0, dec_valid=0, ir=0, inst_flags=0, illegal=0.
REQ-027 Reset mid-REQ discards the pending fetch; a late ack after release in IDLE is ignored.

Configuration
REQ-028 Macro ILLEGAL_TRAP_EN defined: illegal word on ack -> TRAP after VALID handshake completes; TRAP holds dec_valid=0, imem_req=0, illegal=1 until reset.
REQ-029 ILLEGAL_TRAP_EN undefined: illegal word presented with inst_flags=0, illegal=1, normal VALID flow continues; TRAP state absent.

Verification
REQ-030 pc=0x00400000, ack after 3 wait cycles, rdata=0x00221820 -> imem_addr=0x00400000 during REQ, then dec_valid=1, inst_flags=1<<0, ir=0x00221820.
REQ-031 rdata=0x8C220004 with dec_ready=0 for 5 cycles -> flags=1<<22 held stable 5 cycles; dec_ready=1, fetch_en=1 -> REQ next cycle.
REQ-032 rdata=0x0C000010 -> inst_flags=1<<30; rdata=0x00000000 -> inst_flags=1<<10, illegal=0.
REQ-033 rdata=0xFC000000 -> illegal=1, flags=0; with ILLEGAL_TRAP_EN, after handshake block stays in TRAP with imem_req=0 for 20 cycles; without, next fetch proceeds.
REQ-034 rst_n low during REQ -> outputs zero immediately; ack one cycle after release -> no dec_valid.
